// File: rtl/echo_delay_ctrl.sv
// Echo delay-line controller: one read-modify-write slot per codec sample
// against a single-port delay RAM, producing the delayed echo sample.
module echo_delay_ctrl #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              new_sample_ready,
   input  logic [DATA_W-1:0] sample_in,
   input  logic [ADDR_W-1:0] delay_len,
   input  logic              echo_enable,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic [DATA_W-1:0] echo_sample,
   output logic              echo_valid,
   output logic              primed,
   output logic              busy,
   output logic              overrun
);

   typedef enum logic [2:0] {IDLE, RD, RDW, WR, DONE} state_t;

   state_t            state, state_nx;
   logic              nsr_q;
   logic              pending;
   logic [ADDR_W-1:0] wr_ptr, rd_ptr, fill_cnt, delay_q;
   logic [DATA_W-1:0] samp_q, pend_q, rd_q, echo_q, echo_new;
   logic              primed_q, overrun_q, we_raw;
   logic              req, start;

   assign req    = new_sample_ready & ~nsr_q;
   assign start  = (state == IDLE) & (req | pending);
   assign rd_ptr = wr_ptr - delay_q;

   always_comb begin
      state_nx = state;
      ram_addr = wr_ptr;
      we_raw   = 1'b0;
      case (state)
         IDLE: if (req || pending) state_nx = RD;
         RD: begin
            ram_addr = rd_ptr;
            state_nx = RDW;
         end
         RDW: begin
            ram_addr = rd_ptr;
            state_nx = WR;
         end
         WR: begin
            we_raw   = 1'b1;
            state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Write strobe is masked by reset directly so an abort in WR never writes.
   assign ram_we  = we_raw & ~reset;
   assign ram_din = samp_q;

   // Zero delay means the echo is the sample being written this slot.
   assign echo_new    = (echo_enable && primed_q) ?
                        ((delay_q == '0) ? samp_q : rd_q) : '0;
   assign echo_valid  = (state == DONE);
   assign echo_sample = echo_valid ? echo_new : echo_q;
   assign primed      = primed_q;
   assign busy        = (state != IDLE);
   assign overrun     = overrun_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         nsr_q     <= 1'b1;
         pending   <= 1'b0;
         wr_ptr    <= '0;
         fill_cnt  <= '0;
         delay_q   <= '0;
         samp_q    <= '0;
         pend_q    <= '0;
         rd_q      <= '0;
         echo_q    <= '0;
         primed_q  <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state     <= state_nx;
         nsr_q     <= new_sample_ready;
         overrun_q <= req & pending;

         if (start) begin
            delay_q <= delay_len;
            if (delay_len != delay_q) begin
               fill_cnt <= '0;
               primed_q <= 1'b0;
            end
            if (pending) begin
               samp_q  <= pend_q;
               pending <= 1'b0;
            end else begin
               samp_q <= sample_in;
            end
         end else if (req && !pending) begin
            pending <= 1'b1;
            pend_q  <= sample_in;
         end

         // primed for this slot reflects fill level before its own write.
         if (state == WR) begin
            rd_q     <= ram_dout;
            primed_q <= (fill_cnt >= delay_q);
            if (fill_cnt < delay_q) fill_cnt <= fill_cnt + 1'b1;
            wr_ptr   <= wr_ptr + 1'b1;
         end

         if (state == DONE) echo_q <= echo_new;
      end
   end

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Bench for echo_delay_ctrl: slot-schedule/history model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_echo_delay_ctrl;
   localparam int AW = 4;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          nsr = 1'b0;
   logic [DW-1:0] sample_in = '0;
   logic [AW-1:0] delay_len = '0;
   logic          echo_enable = 1'b1;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout = '0;
   logic [DW-1:0] echo_sample;
   logic          echo_valid, primed, busy, overrun;

   echo_delay_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .new_sample_ready(nsr), .sample_in(sample_in),
      .delay_len(delay_len), .echo_enable(echo_enable), .ram_addr(ram_addr),
      .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
      .echo_sample(echo_sample), .echo_valid(echo_valid), .primed(primed),
      .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Single-port RAM with one-cycle read latency.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   initial for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: each accepted request becomes a slot; echo is the sample written
   // delay slots earlier, valid once delay slots have been written since the
   // last delay change.
   int            cyc = 0;
   bit            armed = 0;
   bit            m_prev = 1;
   bit            m_pend = 0;
   logic [DW-1:0] m_pend_s;
   int            idle_from = 0;
   int            done_at = -1;
   logic [DW-1:0] slot_val;
   bit            slot_pr;
   int            m_d = 0;
   int            m_cnt = 0;
   logic [DW-1:0] hist [$];
   bit            exp_primed = 0;
   int            pr_at = -1;
   bit            pr_new;
   bit            exp_ov = 0;
   logic [DW-1:0] hold = '0;
   logic [DW-1:0] got [$];
   bit            gotp [$];
   int            nvalid = 0;
   int            nov = 0;

   task automatic m_start(input logic [DW-1:0] s, input int c);
      if (int'(delay_len) != m_d) begin
         m_d = int'(delay_len);
         m_cnt = 0;
         exp_primed = 0;
      end
      slot_pr  = (m_cnt >= m_d);
      slot_val = !slot_pr ? '0 : ((m_d == 0) ? s : hist[hist.size() - m_d]);
      hist.push_back(s);
      m_cnt++;
      done_at   = c + 4;
      idle_from = c + 5;
      pr_at     = c + 4;
      pr_new    = slot_pr;
   endtask

   always @(posedge clk) begin
      int c;
      bit req;
      c = cyc;
      if (reset) begin
         armed = 1; m_prev = 1; m_pend = 0; idle_from = c + 1; done_at = -1;
         pr_at = -1; exp_primed = 0; m_d = 0; m_cnt = 0; hist.delete();
         exp_ov = 0; hold = '0;
      end else begin
         req = nsr && !m_prev;
         m_prev = nsr;
         exp_ov = 0;
         if (c + 1 == pr_at) exp_primed = pr_new;
         if (c >= idle_from && m_pend) begin
            m_start(m_pend_s, c);
            m_pend = 0;
            if (req) exp_ov = 1;
         end else if (c >= idle_from && req) begin
            m_start(sample_in, c);
         end else if (req) begin
            if (m_pend) exp_ov = 1;
            else begin
               m_pend = 1;
               m_pend_s = sample_in;
            end
         end
      end
      cyc = c + 1;
   end

   always @(negedge clk) begin
      bit ev;
      logic [DW-1:0] es;
      if (armed) begin
         ev = (cyc == done_at);
         es = ev ? ((echo_enable && slot_pr) ? slot_val : '0) : hold;
         chk("echo_valid", echo_valid, ev);
         chk("echo_sample", echo_sample, es);
         chk("primed", primed, exp_primed);
         chk("busy", busy, cyc < idle_from);
         chk("overrun", overrun, exp_ov);
         if (reset) chk("ram_we_in_reset", ram_we, 0);
         if (ev) begin
            hold = es;
            got.push_back(echo_sample);
            gotp.push_back(primed);
            nvalid++;
         end
         if (overrun) nov++;
      end
   end

   task automatic send(input logic [DW-1:0] s);
      @(posedge clk); #1 nsr = 1; sample_in = s;
      @(posedge clk); #1 nsr = 0;
      repeat (5) @(posedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk); #1 reset = 1;
      repeat (2) @(posedge clk);
      #1 reset = 0;
   endtask

   task automatic expect_seq(input string nm, input int base, input int n,
                             input logic [DW-1:0] ev [8], input bit pv [8]);
      for (int i = 0; i < n; i++) begin
         chk({nm, "_echo"}, (base + i < got.size()) ? got[base + i] : 32'hdead, ev[i]);
         chk({nm, "_primed"}, (base + i < gotp.size()) ? gotp[base + i] : 1'b0, pv[i]);
      end
   endtask

   initial begin
      int base, nv0, ov0;
      logic [DW-1:0] e [8];
      bit p [8];

      repeat (3) @(posedge clk);
      #1 reset = 0;
      #1;
      chk("rst_echo_sample", echo_sample, 0);
      chk("rst_busy", busy, 0);
      chk("rst_primed", primed, 0);
      chk("rst_ram_addr", ram_addr, 0);

      // Delay 3, samples 1..6.
      delay_len = 3; base = got.size();
      for (int s = 1; s <= 6; s++) send(DW'(s));
      e = '{0, 0, 0, 1, 2, 3, 0, 0}; p = '{0, 0, 0, 1, 1, 1, 0, 0};
      expect_seq("d3", base, 6, e, p);

      // Delay 3 across a pointer wrap.
      do_reset(); base = got.size();
      for (int s = 1; s <= 20; s++) send(DW'(s));
      chk("wrap_16th", (base + 15 < got.size()) ? got[base + 15] : 32'hdead, 13);
      chk("wrap_20th", (base + 19 < got.size()) ? got[base + 19] : 32'hdead, 17);

      // Shrink delay to 2, then disabled and re-enabled slot.
      delay_len = 2; base = got.size();
      for (int s = 21; s <= 24; s++) send(DW'(s));
      echo_enable = 0; send(25);
      echo_enable = 1; send(26);
      e = '{0, 0, 21, 22, 0, 24, 0, 0}; p = '{0, 0, 1, 1, 1, 1, 0, 0};
      expect_seq("d2", base, 6, e, p);

      // Level held high through reset release is not a request.
      @(posedge clk); #1 reset = 1; nsr = 1;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      nv0 = nvalid;
      repeat (4) @(posedge clk);
      #1 nsr = 0;
      repeat (6) @(posedge clk);
      chk("held_level_no_req", nvalid - nv0, 0);

      // Zero delay.
      delay_len = 0; base = got.size();
      send(5); send(9);
      e = '{5, 9, 0, 0, 0, 0, 0, 0}; p = '{1, 1, 0, 0, 0, 0, 0, 0};
      expect_seq("d0", base, 2, e, p);

      // Three edges two cycles apart: serviced, pending, dropped.
      do_reset(); delay_len = 3; nv0 = nvalid; ov0 = nov;
      @(posedge clk); #1 nsr = 1; sample_in = 7;
      @(posedge clk); #1 nsr = 0;
      @(posedge clk); #1 nsr = 1; sample_in = 8;
      @(posedge clk); #1 nsr = 0;
      @(posedge clk); #1 nsr = 1; sample_in = 9;
      @(posedge clk); #1 nsr = 0;
      repeat (12) @(posedge clk);
      chk("burst_valids", nvalid - nv0, 2);
      chk("burst_overruns", nov - ov0, 1);

      // Reset asserted while the slot is in WR.
      nv0 = nvalid;
      @(posedge clk); #1 nsr = 1; sample_in = 99;
      @(posedge clk); #1 nsr = 0;
      @(posedge clk); #1;
      @(posedge clk); #1 reset = 1;
      @(posedge clk); #1 reset = 0;
      #1;
      chk("wr_abort_busy", busy, 0);
      chk("wr_abort_addr", ram_addr, 0);
      chk("wr_abort_echo", echo_sample, 0);
      chk("wr_abort_no_valid", nvalid - nv0, 0);
      base = got.size();
      for (int s = 1; s <= 6; s++) send(DW'(s));
      e = '{0, 0, 0, 1, 2, 3, 0, 0}; p = '{0, 0, 0, 1, 1, 1, 0, 0};
      expect_seq("after_abort", base, 6, e, p);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
